// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the register file and scoreboard.
package pipe_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;

   typedef logic [ADDR_W-1:0]   reg_idx_t;
   typedef logic [DATA_W-1:0]   word_t;
   typedef logic [NUM_REGS-1:0] reg_mask_t;

   function automatic reg_mask_t idx_onehot(reg_idx_t idx);
      return reg_mask_t'(1) << idx;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file; master = pipeline, slave = regfile_scoreboard.
interface regfile_scoreboard_if;
   import pipe_pkg::*;

   logic      wb_we;
   reg_idx_t  wb_addr;
   word_t     wb_data;
   reg_idx_t  rs1_addr;
   reg_idx_t  rs2_addr;
   word_t     rs1_data;
   word_t     rs2_data;
   logic      iss_valid;
   logic      iss_rs1_used;
   logic      iss_rs2_used;
   logic      iss_rd_we;
   reg_idx_t  iss_rd;
   logic      iss_ready;
   logic      flush;
   reg_mask_t busy_vec;

   modport master (
      output wb_we, wb_addr, wb_data, rs1_addr, rs2_addr,
      output iss_valid, iss_rs1_used, iss_rs2_used, iss_rd_we, iss_rd, flush,
      input  rs1_data, rs2_data, iss_ready, busy_vec
   );

   modport slave (
      input  wb_we, wb_addr, wb_data, rs1_addr, rs2_addr,
      input  iss_valid, iss_rs1_used, iss_rs2_used, iss_rd_we, iss_rd, flush,
      output rs1_data, rs2_data, iss_ready, busy_vec
   );

endinterface

// File: rtl/regfile_array.sv
// GPR storage: one write port, two combinational read ports, register 0 reads as zero.
module regfile_array
   import pipe_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     we,
   input  reg_idx_t waddr,
   input  word_t    wdata,
   input  reg_idx_t raddr1,
   input  reg_idx_t raddr2,
   output word_t    rdata1,
   output word_t    rdata2
);

   word_t regs_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && waddr != '0) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file read side with busy scoreboard and RAW/WAW issue stall.
// Define REGFILE_BYPASS_EN to forward writeback data/release busy in the writeback cycle.
module regfile_scoreboard
   import pipe_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_scoreboard_if.slave  bus
);

`ifdef REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   word_t     arr_rs1;
   word_t     arr_rs2;
   reg_mask_t busy_q;
   reg_mask_t busy_d;
   reg_mask_t wb_release;
   reg_mask_t busy_eff;
   logic      fwd1;
   logic      fwd2;
   logic      h1;
   logic      h2;
   logic      hw;
   logic      ready;
   logic      fire;

   regfile_array u_array (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (bus.wb_we),
      .waddr  (bus.wb_addr),
      .wdata  (bus.wb_data),
      .raddr1 (bus.rs1_addr),
      .raddr2 (bus.rs2_addr),
      .rdata1 (arr_rs1),
      .rdata2 (arr_rs2)
   );

   assign fwd1 = Bypass && bus.wb_we && bus.wb_addr == bus.rs1_addr && bus.rs1_addr != '0;
   assign fwd2 = Bypass && bus.wb_we && bus.wb_addr == bus.rs2_addr && bus.rs2_addr != '0;

   // Outputs are forced quiet while reset is held, before storage has been cleared.
   assign bus.rs1_data = !rst_n ? '0 : (fwd1 ? bus.wb_data : arr_rs1);
   assign bus.rs2_data = !rst_n ? '0 : (fwd2 ? bus.wb_data : arr_rs2);

   assign wb_release = (Bypass && bus.wb_we) ? idx_onehot(bus.wb_addr) : '0;
   assign busy_eff   = busy_q & ~wb_release;

   assign h1 = bus.iss_rs1_used && bus.rs1_addr != '0 && busy_eff[bus.rs1_addr];
   assign h2 = bus.iss_rs2_used && bus.rs2_addr != '0 && busy_eff[bus.rs2_addr];
   assign hw = bus.iss_rd_we && bus.iss_rd != '0 && busy_eff[bus.iss_rd];

   assign ready         = !rst_n || !(bus.iss_valid && (h1 || h2 || hw));
   assign fire          = bus.iss_valid && ready;
   assign bus.iss_ready = ready;
   assign bus.busy_vec  = busy_q;

   // Clear from writeback first so a same-cycle issue to that index wins.
   always_comb begin
      busy_d = busy_q;
      if (bus.flush) begin
         busy_d = '0;
      end else begin
         if (bus.wb_we) begin
            busy_d[bus.wb_addr] = 1'b0;
         end
         if (fire && bus.iss_rd_we && bus.iss_rd != '0) begin
            busy_d[bus.iss_rd] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic vs a model.
module tb_regfile_scoreboard;
   import pipe_pkg::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   regfile_scoreboard_if bus ();

   regfile_scoreboard dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model: plain arrays of register values and pending-write flags.
   logic [31:0] m_regs [32];
   bit   [31:0] m_busy;

   function automatic bit fwd_hit(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
      return bus.wb_we && bus.wb_addr == a && a != 5'd0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'd0;
      if (fwd_hit(a)) return bus.wb_data;
      return m_regs[a];
   endfunction

   function automatic bit pending(input logic [4:0] a);
      return a != 5'd0 && m_busy[a] && !fwd_hit(a);
   endfunction

   function automatic bit exp_ready();
      bit hazard;
      if (!rst_n) return 1'b1;
      hazard = (bus.iss_rs1_used && pending(bus.rs1_addr)) ||
               (bus.iss_rs2_used && pending(bus.rs2_addr)) ||
               (bus.iss_rd_we && pending(bus.iss_rd));
      return !(bus.iss_valid && hazard);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic compare_model();
      check("rs1_data", bus.rs1_data, exp_read(bus.rs1_addr));
      check("rs2_data", bus.rs2_data, exp_read(bus.rs2_addr));
      check("iss_ready", 32'(bus.iss_ready), 32'(exp_ready()));
      check("busy_vec", bus.busy_vec, m_busy);
   endtask

   task automatic model_update();
      bit fire;
      fire = bus.iss_valid && exp_ready();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_busy = '0;
      end else begin
         if (bus.wb_we && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
         if (bus.flush) begin
            m_busy = '0;
         end else begin
            if (bus.wb_we) m_busy[bus.wb_addr] = 1'b0;
            if (fire && bus.iss_rd_we && bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      compare_model();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      bus.wb_we        = 1'b0;
      bus.wb_addr      = '0;
      bus.wb_data      = '0;
      bus.rs1_addr     = '0;
      bus.rs2_addr     = '0;
      bus.iss_valid    = 1'b0;
      bus.iss_rs1_used = 1'b0;
      bus.iss_rs2_used = 1'b0;
      bus.iss_rd_we    = 1'b0;
      bus.iss_rd       = '0;
      bus.flush        = 1'b0;
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      bus.iss_valid = 1'b1;
      bus.iss_rd_we = 1'b1;
      bus.iss_rd    = rd;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      bus.wb_we   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      m_busy  = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      rst_n = 1'b0;
      idle();
      advance();
      advance();
      rst_n = 1'b1;

      // Reset state
      bus.rs1_addr = 5'd5;
      settle();
      check("reset_busy", bus.busy_vec, 32'd0);
      check("reset_ready", 32'(bus.iss_ready), 32'd1);
      check("reset_rs1", bus.rs1_data, 32'd0);
      advance();

      // Write r5, read back next cycle
      idle(); wb(5'd5, 32'hDEADBEEF);
      settle(); advance();
      idle(); bus.rs1_addr = 5'd5;
      settle();
      check("wr_r5", bus.rs1_data, 32'hDEADBEEF);
      advance();

      // Writes to r0 are dropped
      idle(); wb(5'd0, 32'h1234);
      settle();
      check("r0_same_cycle", bus.rs1_data, 32'd0);
      advance();
      idle();
      settle();
      check("r0_read", bus.rs1_data, 32'd0);
      check("r0_busy", 32'(bus.busy_vec[0]), 32'd0);
      advance();

      // RAW on r7 released by writeback
      idle(); issue_rd(5'd7);
      settle();
      check("raw_issue_rd7", 32'(bus.iss_ready), 32'd1);
      advance();
      idle(); bus.iss_valid = 1'b1; bus.iss_rs2_used = 1'b1; bus.rs2_addr = 5'd7;
      settle();
      check("raw_stall", 32'(bus.iss_ready), 32'd0);
      check("raw_busy7", bus.busy_vec, 32'h0000_0080);
      advance();
      wb(5'd7, 32'hCAFE0007);
      settle();
`ifdef REGFILE_BYPASS_EN
      check("raw_wb_cycle_ready", 32'(bus.iss_ready), 32'd1);
      check("raw_wb_cycle_data", bus.rs2_data, 32'hCAFE0007);
`else
      check("raw_wb_cycle_ready", 32'(bus.iss_ready), 32'd0);
      check("raw_wb_cycle_data", bus.rs2_data, 32'd0);
`endif
      advance();
      bus.wb_we = 1'b0;
      settle();
      check("raw_after_wb_ready", 32'(bus.iss_ready), 32'd1);
      check("raw_after_wb_data", bus.rs2_data, 32'hCAFE0007);
      advance();

      // WAW on r3, then same-cycle writeback + issue leaves r3 busy
      idle(); issue_rd(5'd3);
      settle(); advance();
      settle();
      check("waw_stall", 32'(bus.iss_ready), 32'd0);
      advance();
      idle(); wb(5'd3, 32'h0);
      settle(); advance();
      wb(5'd3, 32'h33); issue_rd(5'd3);
      settle();
      check("wb_issue_ready", 32'(bus.iss_ready), 32'd1);
      advance();
      idle();
      settle();
      check("set_wins_r3", bus.busy_vec, 32'h0000_0008);
      advance();
      wb(5'd3, 32'h33);
      settle(); advance();

      // Flush clears busy, keeps contents
      idle(); issue_rd(5'd2);
      settle(); advance();
      issue_rd(5'd9);
      settle(); advance();
      idle();
      settle();
      check("pre_flush_busy", bus.busy_vec, 32'h0000_0204);
      bus.flush = 1'b1;
      advance();
      idle(); bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd3;
      settle();
      check("flush_busy", bus.busy_vec, 32'd0);
      check("flush_keep_r5", bus.rs1_data, 32'hDEADBEEF);
      check("flush_keep_r3", bus.rs2_data, 32'h33);
      advance();

      // Reset mid-stall
      idle(); issue_rd(5'd4);
      settle(); advance();
      idle(); bus.iss_valid = 1'b1; bus.iss_rs1_used = 1'b1; bus.rs1_addr = 5'd4;
      settle();
      check("rst_pre_stall", 32'(bus.iss_ready), 32'd0);
      advance();
      rst_n = 1'b0;
      settle();
      check("rst_during_ready", 32'(bus.iss_ready), 32'd1);
      advance();
      rst_n = 1'b1;
      idle(); bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd3;
      settle();
      check("rst_busy", bus.busy_vec, 32'd0);
      check("rst_r5", bus.rs1_data, 32'd0);
      check("rst_r3", bus.rs2_data, 32'd0);
      check("rst_ready", 32'(bus.iss_ready), 32'd1);
      advance();

      // Randomized traffic; small index range keeps hazards frequent
      for (int n = 0; n < 3000; n++) begin
         rst_n            = ($urandom_range(0, 199) != 0);
         bus.flush        = ($urandom_range(0, 39) == 0);
         bus.wb_we        = ($urandom_range(0, 99) < 35);
         bus.wb_addr      = 5'($urandom_range(0, 7));
         bus.wb_data      = $urandom;
         bus.rs1_addr     = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         bus.rs2_addr     = 5'($urandom_range(0, 7));
         bus.iss_valid    = ($urandom_range(0, 99) < 70);
         bus.iss_rs1_used = 1'($urandom);
         bus.iss_rs2_used = 1'($urandom);
         bus.iss_rd_we    = ($urandom_range(0, 99) < 60);
         bus.iss_rd       = 5'($urandom_range(0, 7));
         settle();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
